// File: rtl/except_ctrl.sv
// ---------------------------------------------------------------------------
// except_ctrl
//
// Registered exception collector and arbiter for the pipelined MIPS core.
// Collects excepttype vectors from NUM_CH pipeline-stage channels, picks one
// winner (oldest stage first, then by cause), captures its PC as EPC, holds a
// pipeline flush for FLUSH_CYC cycles and then offers the exception to CP0.
//
// Handshake to CP0: exc_valid_o rises once the flush completes and stays high,
// with excepttype_o / exc_code_o / epc_o stable, until cp0_ack_i is sampled
// high on a rising clock edge; the transfer happens on that edge.
//
// Optional build macro: EXCEPT_CTRL_COUNT_EN
//   defined   : exc_count_o is a saturating 16-bit count of taken exceptions
//   undefined : exc_count_o is tied to zero and no counter is built
//
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   ch_valid_i       in   [NUM_CH]      channel carries a real instruction
//   ch_excepttype_i  in   [32*NUM_CH]   per-channel excepttype, ch k at [32k+:32]
//   ch_pc_i          in   [PC_W*NUM_CH] per-channel instruction PC
//   cp0_ack_i        in   CP0 accepted the exception
//   flush_o          out  flush all pipeline stages
//   exc_valid_o      out  exception request to CP0
//   excepttype_o     out  [32] one-hot selected cause
//   exc_code_o       out  [5]  cause code (RI=10, Ov=12, Sys=8, eret=31)
//   epc_o            out  [PC_W] PC of the winning channel
//   busy_o           out  controller not idle
//   exc_count_o      out  [16] taken-exception count
// ---------------------------------------------------------------------------
module except_ctrl #(
  parameter int NUM_CH    = 3,
  parameter int FLUSH_CYC = 2,
  parameter int PC_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [32*NUM_CH-1:0]     ch_excepttype_i,
  input  logic [PC_W*NUM_CH-1:0]   ch_pc_i,
  input  logic                     cp0_ack_i,
  output logic                     flush_o,
  output logic                     exc_valid_o,
  output logic [31:0]              excepttype_o,
  output logic [4:0]               exc_code_o,
  output logic [PC_W-1:0]          epc_o,
  output logic                     busy_o,
  output logic [15:0]              exc_count_o
);

  // Only syscall (8), RI (9), overflow (10) and eret (12) are meaningful.
  localparam logic [31:0] SIG_MASK = 32'h0000_1700;
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               flush_q, flush_d;
  logic               exc_valid_q, exc_valid_d;
  logic [31:0]        excepttype_q, excepttype_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [PC_W-1:0]    epc_q, epc_d;

  // Candidate selection results
  logic               cand_any;
  logic [31:0]        win_type;
  logic [PC_W-1:0]    win_pc;
  logic [31:0]        masked_v;
  logic [31:0]        sel_type;
  logic [4:0]         sel_code;

  // -------------------------------------------------------------------------
  // Channel arbitration: scanning upward and overwriting on every candidate
  // leaves the highest-indexed (oldest) candidate as the winner.
  // -------------------------------------------------------------------------
  always_comb begin
    cand_any = 1'b0;
    win_type = '0;
    win_pc   = '0;
    masked_v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      masked_v = ch_excepttype_i[32*k +: 32] & SIG_MASK;
      if (ch_valid_i[k] && (masked_v != 32'h0)) begin
        cand_any = 1'b1;
        win_type = masked_v;
        win_pc   = ch_pc_i[PC_W*k +: PC_W];
      end
    end
  end

  // Cause priority inside the winning channel: RI > Ov > Sys > eret.
  always_comb begin
    sel_type = 32'h0;
    sel_code = 5'd0;
    if (win_type[9]) begin
      sel_type = 32'h0000_0200;
      sel_code = 5'd10;
    end else if (win_type[10]) begin
      sel_type = 32'h0000_0400;
      sel_code = 5'd12;
    end else if (win_type[8]) begin
      sel_type = 32'h0000_0100;
      sel_code = 5'd8;
    end else if (win_type[12]) begin
      sel_type = 32'h0000_1000;
      sel_code = 5'h1F;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cand_any)                state_d = ST_FLUSH;
      ST_FLUSH: if (flush_cnt_q == '0)       state_d = ST_REQ;
      ST_REQ:   if (cp0_ack_i)               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / datapath next values. All outputs are registered so the
  // flush and request lines are glitch-free toward the pipeline and CP0.
  // -------------------------------------------------------------------------
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    flush_d      = flush_q;
    exc_valid_d  = exc_valid_q;
    excepttype_d = excepttype_q;
    exc_code_d   = exc_code_q;
    epc_d        = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          excepttype_d = sel_type;
          exc_code_d   = sel_code;
          epc_d        = win_pc;
          flush_d      = 1'b1;
          flush_cnt_d  = CNT_W'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        // Counter reaching zero marks the last flush cycle.
        if (flush_cnt_q == '0) begin
          flush_d     = 1'b0;
          exc_valid_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      ST_REQ: begin
        // EPC is kept after the ack so CP0 may still read it.
        if (cp0_ack_i) begin
          exc_valid_d  = 1'b0;
          excepttype_d = 32'h0;
          exc_code_d   = 5'd0;
        end
      end
      default: begin
        flush_d     = 1'b0;
        exc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q  <= '0;
      flush_q      <= 1'b0;
      exc_valid_q  <= 1'b0;
      excepttype_q <= 32'h0;
      exc_code_q   <= 5'd0;
      epc_q        <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      flush_q      <= flush_d;
      exc_valid_q  <= exc_valid_d;
      excepttype_q <= excepttype_d;
      exc_code_q   <= exc_code_d;
      epc_q        <= epc_d;
    end
  end

  assign flush_o      = flush_q;
  assign exc_valid_o  = exc_valid_q;
  assign excepttype_o = excepttype_q;
  assign exc_code_o   = exc_code_q;
  assign epc_o        = epc_q;
  assign busy_o       = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Optional taken-exception counter
  // -------------------------------------------------------------------------
`ifdef EXCEPT_CTRL_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == ST_IDLE) && cand_any && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign exc_count_o = count_q;
`else
  assign exc_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// ---------------------------------------------------------------------------
// tb_except_ctrl
//
// Directed self-checking bench for except_ctrl (NUM_CH=3, FLUSH_CYC=2,
// PC_W=32). Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_except_ctrl;

  localparam int NUM_CH    = 3;
  localparam int FLUSH_CYC = 2;
  localparam int PC_W      = 32;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]      ch_valid_i;
  logic [32*NUM_CH-1:0]   ch_excepttype_i;
  logic [PC_W*NUM_CH-1:0] ch_pc_i;
  logic                   cp0_ack_i;
  logic                   flush_o;
  logic                   exc_valid_o;
  logic [31:0]            excepttype_o;
  logic [4:0]             exc_code_o;
  logic [PC_W-1:0]        epc_o;
  logic                   busy_o;
  logic [15:0]            exc_count_o;

  except_ctrl #(
    .NUM_CH    (NUM_CH),
    .FLUSH_CYC (FLUSH_CYC),
    .PC_W      (PC_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ch_valid_i      (ch_valid_i),
    .ch_excepttype_i (ch_excepttype_i),
    .ch_pc_i         (ch_pc_i),
    .cp0_ack_i       (cp0_ack_i),
    .flush_o         (flush_o),
    .exc_valid_o     (exc_valid_o),
    .excepttype_o    (excepttype_o),
    .exc_code_o      (exc_code_o),
    .epc_o           (epc_o),
    .busy_o          (busy_o),
    .exc_count_o     (exc_count_o)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];   // expected EPC of each request, in order

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (always entered and left on a falling edge)
  // -------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [31:0] t2, input logic [31:0] t1, input logic [31:0] t0,
                       input logic [31:0] p2, input logic [31:0] p1, input logic [31:0] p0);
    ch_valid_i      = v;
    ch_excepttype_i = {t2, t1, t0};
    ch_pc_i         = {p2, p1, p0};
  endtask

  task automatic idle_inputs();
    ch_valid_i      = '0;
    ch_excepttype_i = '0;
    ch_pc_i         = '0;
  endtask

  // Inputs already driven by caller. Walks one full exception: 1-cycle
  // latency, FLUSH_CYC flush cycles, request, ack, return to idle.
  task automatic run_exc(input string tag, input logic [31:0] exp_type,
                         input logic [4:0] exp_code);
    logic [31:0] exp_epc;
    exp_epc = exp_q.pop_front();
    step();
    check({tag, ".flush1"}, 64'(flush_o), 64'd1);
    check({tag, ".busy"}, 64'(busy_o), 64'd1);
    idle_inputs();
    step();
    check({tag, ".flush2"}, 64'(flush_o), 64'd1);
    check({tag, ".novalid_in_flush"}, 64'(exc_valid_o), 64'd0);
    step();
    check({tag, ".flush_end"}, 64'(flush_o), 64'd0);
    check({tag, ".valid"}, 64'(exc_valid_o), 64'd1);
    check({tag, ".type"}, 64'(excepttype_o), 64'(exp_type));
    check({tag, ".code"}, 64'(exc_code_o), 64'(exp_code));
    check({tag, ".epc"}, 64'(epc_o), 64'(exp_epc));
    cp0_ack_i = 1'b1;
    step();
    cp0_ack_i = 1'b0;
    check({tag, ".valid_after_ack"}, 64'(exc_valid_o), 64'd0);
    check({tag, ".type_after_ack"}, 64'(excepttype_o), 64'd0);
    check({tag, ".code_after_ack"}, 64'(exc_code_o), 64'd0);
    check({tag, ".epc_kept"}, 64'(epc_o), 64'(exp_epc));
    check({tag, ".idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flush"}, 64'(flush_o), 64'd0);
    check({tag, ".valid"}, 64'(exc_valid_o), 64'd0);
    check({tag, ".type"}, 64'(excepttype_o), 64'd0);
    check({tag, ".code"}, 64'(exc_code_o), 64'd0);
    check({tag, ".epc"}, 64'(epc_o), 64'd0);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".count"}, 64'(exc_count_o), 64'd0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [15:0] exp_count;

  initial begin
    idle_inputs();
    cp0_ack_i = 1'b0;
    rst_n     = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // 1: syscall on ch0
    drive(3'b001, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h8000_0010);
    exp_q.push_back(32'h8000_0010);
    run_exc("sys_ch0", 32'h100, 5'd8);

    // 2: ch0 RI vs ch2 eret, oldest channel wins
    drive(3'b101, 32'h1000, 32'h0, 32'h200, 32'h8000_0200, 32'h0, 32'h8000_0100);
    exp_q.push_back(32'h8000_0200);
    run_exc("ch2_wins", 32'h1000, 5'h1F);

    // 3: multi-cause 0x700 plus ignored high bits -> RI
    drive(3'b010, 32'h0, 32'hFFFF_E8F7 | 32'h700, 32'h0, 32'h0, 32'h8000_0444, 32'h0);
    exp_q.push_back(32'h8000_0444);
    run_exc("ri_prio", 32'h200, 5'd10);

    // 3b: same vector but channel not valid; only ignored bits on ch0 -> no flush
    drive(3'b001, 32'h0, 32'h700, 32'h0000_E0FF, 32'h0, 32'h8000_0444, 32'h0);
    step();
    check("invalid_ch.flush", 64'(flush_o), 64'd0);
    step();
    check("invalid_ch.busy", 64'(busy_o), 64'd0);
    idle_inputs();
    step();

    // 4: overflow; new exception and ack during FLUSH, new exception during REQ
    drive(3'b001, 32'h0, 32'h0, 32'h400, 32'h0, 32'h0, 32'h8000_0A00);
    step();
    check("inject.flush1", 64'(flush_o), 64'd1);
    drive(3'b100, 32'h100, 32'h0, 32'h0, 32'h8000_0F00, 32'h0, 32'h0);
    cp0_ack_i = 1'b1;
    step();
    cp0_ack_i = 1'b0;
    check("inject.flush2", 64'(flush_o), 64'd1);
    step();
    check("inject.req_valid", 64'(exc_valid_o), 64'd1);
    check("inject.req_type", 64'(excepttype_o), 64'h400);
    check("inject.req_code", 64'(exc_code_o), 64'd12);
    repeat (3) step();
    check("inject.held_valid", 64'(exc_valid_o), 64'd1);
    check("inject.held_epc", 64'(epc_o), 64'h8000_0A00);
    check("inject.held_noflush", 64'(flush_o), 64'd0);
    idle_inputs();
    cp0_ack_i = 1'b1;
    step();
    cp0_ack_i = 1'b0;
    check("inject.ack_valid", 64'(exc_valid_o), 64'd0);
    step();
    check("inject.no_replay", 64'(flush_o), 64'd0);

    // 5: reset in the middle of REQ
    drive(3'b010, 32'h0, 32'h100, 32'h0, 32'h0, 32'h8000_0C00, 32'h0);
    step();
    idle_inputs();
    repeat (2) step();
    check("rst_mid.in_req", 64'(exc_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid.still_idle", 64'(busy_o), 64'd0);

    // three exceptions after reset for the counter
    drive(3'b100, 32'h400, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 32'h0);
    exp_q.push_back(32'h8000_1000);
    run_exc("post_rst1", 32'h400, 5'd12);
    drive(3'b011, 32'h0, 32'h1100, 32'h200, 32'h0, 32'h8000_2000, 32'h8000_2004);
    exp_q.push_back(32'h8000_2000);
    run_exc("post_rst2", 32'h100, 5'd8);
    drive(3'b001, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h8000_3000);
    exp_q.push_back(32'h8000_3000);
    run_exc("post_rst3", 32'h1000, 5'h1F);

`ifdef EXCEPT_CTRL_COUNT_EN
    exp_count = 16'd3;
`else
    exp_count = 16'd0;
`endif
    check("count", 64'(exc_count_o), 64'(exp_count));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Parametrised, registered exception collector and arbiter for the pipelined MIPS core.
- Accepts excepttype vectors from NUM_CH pipeline-stage channels, using the existing encoding:
  - 0x100 syscall
  - 0x200 invalid instruction
  - 0x400 overflow
  - 0x1000 eret
- Selects one winner, captures its PC as EPC, and drives a multi-cycle pipeline flush.
- Hands the exception to CP0 with a valid/ack handshake. Sits between the ID/EX/MEM exception paths and CP0.

Parameters:
- NUM_CH, 3, number of source channels; channel NUM_CH-1 is the oldest (deepest) stage.
- FLUSH_CYC, 2, cycles flush_o stays high (>=1).
- PC_W, 32, PC/EPC width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_valid_i  in  NUM_CH  channel carries a real instruction.
- ch_excepttype_i  in  32*NUM_CH  per-channel excepttype; channel k occupies bits [32k+31:32k].
- ch_pc_i  in  PC_W*NUM_CH  per-channel instruction PC.
- cp0_ack_i  in  1  CP0 accepted the exception.
- flush_o  out  1  flush all pipeline stages.
- exc_valid_o  out  1  exception request to CP0.
- excepttype_o  out  32  one-hot code of the selected cause.
- exc_code_o  out  5  cause code: RI=10, Ov=12, Sys=8, eret=5'h1F.
- epc_o  out  PC_W  PC of the winning channel.
- busy_o  out  1  FSM not in IDLE.
- exc_count_o  out  16  taken-exception count (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all outputs 0; FSM to IDLE; counter 0.
  - Applies at any time, including mid-FLUSH or mid-REQ; the pending exception is discarded.
- Masking:
  - Only bits 8, 9, 10, 12 are significant; all other bits are ignored.
  - A channel is a candidate when ch_valid_i[k]=1 and its masked vector is nonzero.
- Channel priority: highest-indexed candidate (oldest instruction) wins.
- Cause priority within the winning channel: RI(bit9) > Ov(bit10) > Sys(bit8) > eret(bit12). Exactly one bit is set in excepttype_o.
- FSM has three states: IDLE, FLUSH, REQ.
- IDLE:
  - Evaluates candidates every cycle.
  - If any candidate exists, on the next edge: register excepttype_o, exc_code_o, epc_o; set flush_o=1; load flush counter with FLUSH_CYC-1; go to FLUSH.
  - Latency is 1 cycle from candidate to flush_o.
- FLUSH:
  - flush_o=1 for exactly FLUSH_CYC cycles, then go to REQ with flush_o=0 and exc_valid_o=1.
  - Channel inputs are ignored. cp0_ack_i is ignored.
- REQ:
  - exc_valid_o is held with stable excepttype_o, exc_code_o, epc_o until cp0_ack_i=1 is sampled.
  - On that edge: exc_valid_o=0, excepttype_o=0, exc_code_o=0; epc_o retains its value; go to IDLE.
  - Channel inputs are ignored.
- Back-to-back: a candidate present in the first IDLE cycle after an ack is taken normally. Minimum spacing between flushes is FLUSH_CYC+2 cycles.
- busy_o is high in FLUSH and REQ.
- Simultaneous candidates in several channels: only the winner is recorded; the losers are flushed and not replayed.

Optional Feature:
- Macro EXCEPT_CTRL_COUNT_EN.
- Defined: 16-bit counter increments on each IDLE->FLUSH transition and saturates at 16'hFFFF. Its value drives exc_count_o; it is reset to 0 only by rst_n.
- Undefined: no counter logic; exc_count_o is tied to 16'h0000.

Test Plan:
- Reset, then ch0 valid with 0x100 and pc 0x80000010 -> 1 cycle later flush_o=1 for 2 cycles, then exc_valid_o=1, excepttype_o=0x100, exc_code_o=8, epc_o=0x80000010; ack -> next cycle IDLE, exc_valid_o=0.
- ch0 = 0x200, ch2 = 0x1000 (both valid) -> ch2 wins: excepttype_o=0x1000, code 0x1F, epc from ch2.
- Single channel with 0x700 -> excepttype_o=0x200, code 10; the same channel with ch_valid_i=0 -> no flush.
- New exception injected during FLUSH and REQ, and ack pulsed during FLUSH -> both ignored; REQ is held until an ack arrives in REQ.
- rst_n dropped during REQ -> all outputs 0 immediately; after release, a new exception is processed normally. With EXCEPT_CTRL_COUNT_EN, exc_count_o=0 after reset and 3 after three handled exceptions.
